bg_vram_ctrl: RTL
=================

# bg_vram_ctrl

Sequencer and arbiter for the background VRAM (2048 × 9-bit, single port, 1-cycle read latency) that feeds the GPU background layer. It walks packed background words (three 3-bit palette indices per word) in step with the beam, prefetching one word ahead, and substitutes sky/ground indices outside the pattern band. Cycles not used by display fetches go to a CPU write port with a req/ack handshake. It sits between the beam timing generator, the CPU bus bridge and the BG VRAM instance.

## Interface
Parameters:
- BAND_TOP, 300: first beam line of the pattern band.
- BAND_H, 128: pattern band height in lines.
- WORDS_PER_LINE, 214: packed words per row (ceil(640/3)).
- ROW_BITS, 3: pattern repeats every 2^ROW_BITS rows; WORDS_PER_LINE·2^ROW_BITS ≤ 2048.
- SKY_IDX, 9'd5: index above the band.
- GROUND_IDX, 9'd7: index below the band.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- y  in  10  beam line of the line being fetched/drawn; stable from line_start through the line.
- line_start  in  1  one-cycle strobe in blanking, ≥4 clk before the line's first pixel_en.
- pixel_en  in  1  one-cycle strobe per active pixel; consecutive strobes ≥2 clk apart.
- pixel_index  out  9  palette index, registered.
- vram_addr  out  11  VRAM address, registered.
- vram_din  out  9  VRAM write data, registered.
- vram_we  out  1  VRAM write enable, registered.
- vram_dout  in  9  VRAM read data, valid 1 clk after vram_addr.
- cpu_req  in  1  CPU write request; held with addr/data until ack.
- cpu_addr  in  11  CPU write address.
- cpu_data  in  9  CPU write data.
- cpu_ack  out  1  one-cycle grant pulse.

## Operation
- Band test: in_band = (y ≥ BAND_TOP) && (y < BAND_TOP+BAND_H); row = (y−BAND_TOP)[ROW_BITS−1:0].
- Word address = row·WORDS_PER_LINE + word_ctr, 11-bit; word_ctr ≥ WORDS_PER_LINE issues no read.
- Registers: cur_word, next_word (9 b), word_ctr (8 b), phase (0..2).
- Fetch FSM: IDLE → (line_start && in_band) PF0 → PF1 → RUN; line_start with !in_band → IDLE.
  - PF0: issue read word 0 → cur_word. PF1: issue read word 1 → next_word. word_ctr=0, phase=0 on line_start.
  - RUN: on pixel_en with phase==2: cur_word←next_word, word_ctr++, phase←0, schedule read of word_ctr+2 (post-increment +1) → next_word. Otherwise phase++.
- Pixel output on pixel_en: !in_band → y<BAND_TOP ? SKY_IDX : GROUND_IDX; in_band → {6'b0, field}, field = cur_word[8:6], [5:3], [2:0] for phase 0,1,2.
- Arbitration per cycle: scheduled display read wins; else cpu_req (not granted last cycle) gets a write. No back-to-back CPU grants (max 1 write / 2 clk).
- Outside band or in IDLE, every non-blocked cycle is available to CPU.
- No coherency: a CPU write to an already-fetched word appears on the next fetch of that word.

## Timing
- Reset: pixel_index=0, vram_addr=0, vram_din=0, vram_we=0, cpu_ack=0, FSM=IDLE, cur/next_word=0, word_ctr=0, phase=0; pending reads and un-acked requests dropped (CPU must keep req high).
- Decision in cycle t → vram_addr/we/din driven t+1; read data captured at end of t+2.
- cpu_ack pulses in the same cycle vram_we=1; CPU may change req/addr/data at that edge.
- pixel_index updates the clock after pixel_en (1-cycle latency); holds otherwise.
- PF0 read issued cycle after line_start, PF1 the next; both words valid ≤4 clk after line_start.
- line_start and pixel_en same cycle: line_start wins, pixel_en ignored. line_start mid-line or with a read in flight: in-flight data discarded, sequence restarts.
- Display read scheduled while a CPU grant is being driven: read issues next cycle; guaranteed before next word boundary (≥6 clk apart).

## Test plan
- Reset mid-prefetch (reset 1 cycle after line_start) → all outputs 0, FSM IDLE, no vram_we, cpu_ack stays 0 for pending req.
- y=100, 3 pixel_en → pixel_index=5 each; y=500 → 7; no VRAM reads issued.
- y=300, VRAM[0]=9'o123, VRAM[1]=9'o456, line_start then 6 pixel_en → pixel_index 1,2,3,4,5,6; read of addr 2 issued after 3rd pixel.
- y=309 (row 1): first read address = 214; word 213 reached → no read of address 214+214.
- cpu_req held with addr=7, data=9'h1FF during in-band pixel stream → display reads never delayed past boundary, cpu_ack once, VRAM[7]=1FF, ack-to-next-grant ≥2 clk.
- line_start and pixel_en asserted together → pixel ignored, prefetch restarts at word 0.

Source files
------------

// File: rtl/bg_vram_ctrl.sv
// Background VRAM sequencer/arbiter: prefetches packed 3x3-bit words ahead of the beam, pixel_index 1 clk after pixel_en.
// VRAM read data captured 2 clk after the decision; CPU writes take spare cycles, req held until a 1-clk ack, max 1 per 2 clk.
module bg_vram_ctrl #(
    parameter int         BAND_TOP       = 300,
    parameter int         BAND_H         = 128,
    parameter int         WORDS_PER_LINE = 214,
    parameter int         ROW_BITS       = 3,
    parameter logic [8:0] SKY_IDX        = 9'd5,
    parameter logic [8:0] GROUND_IDX     = 9'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  y,
    input  logic        line_start,
    input  logic        pixel_en,
    output logic [8:0]  pixel_index,
    output logic [10:0] vram_addr,
    output logic [8:0]  vram_din,
    output logic        vram_we,
    input  logic [8:0]  vram_dout,
    input  logic        cpu_req,
    input  logic [10:0] cpu_addr,
    input  logic [8:0]  cpu_data,
    output logic        cpu_ack
);

    typedef enum logic [1:0] {IDLE, PF0, PF1, RUN} state_t;

    localparam logic [9:0]          TOP_V  = 10'(BAND_TOP);
    localparam logic [10:0]         END_V  = 11'(BAND_TOP + BAND_H);
    localparam logic [ROW_BITS-1:0] TOP_LO = ROW_BITS'(BAND_TOP);
    localparam logic [8:0]          WPL_V  = 9'(WORDS_PER_LINE);
    localparam logic [10:0]         WPL_A  = 11'(WORDS_PER_LINE);

    state_t              state;
    logic [8:0]          cur_word;
    logic [8:0]          next_word;
    logic [7:0]          word_ctr;
    logic [1:0]          phase;
    logic                pend;
    logic [10:0]         pend_addr;
    logic                a_rd;
    logic                a_nxt;
    logic                b_rd;
    logic                b_nxt;

    logic                above;
    logic                in_band;
    logic [ROW_BITS-1:0] row;
    logic [10:0]         base;
    logic [8:0]          ctr_p2;
    logic                ls_band;
    logic                rd_go;
    logic                rd_nxt;
    logic [10:0]         rd_addr;
    logic                cpu_go;
    logic [2:0]          field;

    always_comb begin
        above   = (y < TOP_V);
        in_band = !above && ({1'b0, y} < END_V);
        // Only the low bits of (y - BAND_TOP) matter, and those depend only on the low bits.
        row     = y[ROW_BITS-1:0] - TOP_LO;
        base    = 11'(row) * WPL_A;
        ctr_p2  = {1'b0, word_ctr} + 9'd2;
        ls_band = line_start && in_band;

        rd_go   = 1'b0;
        rd_nxt  = 1'b1;
        rd_addr = pend_addr;
        if (ls_band) begin
            rd_go   = 1'b1;
            rd_nxt  = 1'b0;
            rd_addr = base;
        end else if (!line_start && state == PF0) begin
            rd_go   = 1'b1;
            rd_addr = base + 11'd1;
        end else if (!line_start && state == RUN && pend) begin
            rd_go   = 1'b1;
        end

        // Display reads always win; the ack still visible this cycle blocks an immediate re-grant.
        cpu_go = cpu_req && !cpu_ack && !rd_go;

        case (phase)
            2'd0:    field = cur_word[8:6];
            2'd1:    field = cur_word[5:3];
            default: field = cur_word[2:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pixel_index <= 9'd0;
            vram_addr   <= 11'd0;
            vram_din    <= 9'd0;
            vram_we     <= 1'b0;
            cpu_ack     <= 1'b0;
            cur_word    <= 9'd0;
            next_word   <= 9'd0;
            word_ctr    <= 8'd0;
            phase       <= 2'd0;
            pend        <= 1'b0;
            pend_addr   <= 11'd0;
            a_rd        <= 1'b0;
            a_nxt       <= 1'b0;
            b_rd        <= 1'b0;
            b_nxt       <= 1'b0;
        end else begin
            a_rd    <= rd_go;
            a_nxt   <= rd_nxt;
            b_rd    <= a_rd && !line_start;
            b_nxt   <= a_nxt;
            cpu_ack <= cpu_go;

            if (rd_go) begin
                vram_addr <= rd_addr;
                vram_we   <= 1'b0;
            end else if (cpu_go) begin
                vram_addr <= cpu_addr;
                vram_din  <= cpu_data;
                vram_we   <= 1'b1;
            end else begin
                vram_we   <= 1'b0;
            end

            if (pixel_en && !line_start)
                pixel_index <= in_band ? {6'b0, field} : (above ? SKY_IDX : GROUND_IDX);

            if (line_start) begin
                word_ctr <= 8'd0;
                phase    <= 2'd0;
                pend     <= 1'b0;
                state    <= in_band ? PF0 : IDLE;
            end else begin
                case (state)
                    PF0: state <= PF1;
                    PF1: state <= RUN;
                    RUN: begin
                        if (pend)
                            pend <= 1'b0;
                        if (pixel_en) begin
                            if (phase == 2'd2) begin
                                cur_word  <= next_word;
                                word_ctr  <= word_ctr + 8'd1;
                                phase     <= 2'd0;
                                pend      <= (ctr_p2 < WPL_V);
                                pend_addr <= base + 11'(ctr_p2);
                            end else begin
                                phase <= phase + 2'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Returning read data lands last so it is never overwritten by the word shift.
            if (b_rd && !line_start) begin
                if (b_nxt)
                    next_word <= vram_dout;
                else
                    cur_word  <= vram_dout;
            end
        end
    end

endmodule
